// File: rtl/comparator_seq_nbit.sv
// comparator_seq_nbit: iterative magnitude comparator, MSB slice first, SLICE bits per clock,
// unsigned or two's-complement, with start/busy/done handshake and registered one-hot result.
module comparator_seq_nbit #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AeB,
    output logic             AgB,
    output logic             AlB
);
    localparam int NS = WIDTH / SLICE;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic [2:0]       res_q, res_d;
    logic [WIDTH-1:0] msb;
    logic [SLICE-1:0] sa, sb;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign msb = {sgn, {(WIDTH-1){1'b0}}};
    assign sa  = a_q[idx_q*SLICE +: SLICE];
    assign sb  = b_q[idx_q*SLICE +: SLICE];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        res_d   = res_q;
        if (state_q == IDLE) begin
            if (start) begin
                a_d     = A ^ msb;
                b_d     = B ^ msb;
                idx_d   = IW'(NS - 1);
                state_d = CMP;
            end
        end else if (sa != sb) begin
            res_d   = (sa > sb) ? 3'b010 : 3'b001;
            done_d  = 1'b1;
            state_d = IDLE;
        end else if (idx_q == '0) begin
            res_d   = 3'b100;
            done_d  = 1'b1;
            state_d = IDLE;
        end else begin
            idx_d = idx_q - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy = (state_q == CMP);
    assign done = done_q;
    assign {AeB, AgB, AlB} = res_q;
endmodule

// File: tb/tb_comparator_seq_nbit.sv
// tb_comparator_seq_nbit: directed checks of the iterative comparator at 8/2 and 16/4.
module tb_comparator_seq_nbit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start8 = 1'b0, sgn8 = 1'b0, start16 = 1'b0, sgn16 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic busy8, done8, aeb8, agb8, alb8;
    logic busy16, done16, aeb16, agb16, alb16;
    logic [2:0] res8, res16;
    int checks = 0;
    int failures = 0;
    int lat, bcnt;
    bit seen;

    always #5 clk = ~clk;

    comparator_seq_nbit #(.WIDTH(8), .SLICE(2)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sgn(sgn8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .AeB(aeb8), .AgB(agb8), .AlB(alb8)
    );

    comparator_seq_nbit #(.WIDTH(16), .SLICE(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sgn(sgn16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .AeB(aeb16), .AgB(agb16), .AlB(alb16)
    );

    assign res8  = {aeb8, agb8, alb8};
    assign res16 = {aeb16, agb16, alb16};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one start, then counts negedges until done (lat) and busy samples seen (bcnt).
    task automatic run(input bit w, input logic [15:0] a, input logic [15:0] b, input logic s,
                       output int l, output int bc);
        @(negedge clk);
        if (w) begin
            start16 = 1'b1; a16 = a; b16 = b; sgn16 = s;
        end else begin
            start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sgn8 = s;
        end
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
        l = 0;
        bc = 0;
        while (!(w ? done16 : done8) && l < 20) begin
            if (w ? busy16 : busy8) bc++;
            @(negedge clk);
            l++;
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outs8", {busy8, done8, res8}, 5'b0);
        check("reset_outs16", {busy16, done16, res16}, 5'b0);

        run(1'b0, 16'h00C3, 16'h0043, 1'b0, lat, bcnt);
        check("uns_lat", lat, 1);
        check("uns_res", res8, 3'b010);
        check("uns_busy_in_done", busy8, 1'b0);

        run(1'b0, 16'h00C3, 16'h0043, 1'b1, lat, bcnt);
        check("sgn_lat", lat, 1);
        check("sgn_res", res8, 3'b001);

        run(1'b0, 16'h005A, 16'h005A, 1'b0, lat, bcnt);
        check("eq_lat", lat, 4);
        check("eq_busy_cycles", bcnt, 4);
        check("eq_res", res8, 3'b100);
        @(negedge clk);
        check("done_one_cycle", done8, 1'b0);
        check("result_holds", res8, 3'b100);

        run(1'b0, 16'h0010, 16'h0011, 1'b0, lat, bcnt);
        check("lsb_lat", lat, 4);
        check("lsb_res", res8, 3'b001);

        @(negedge clk);
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h00; sgn8 = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy8, 1'b1);
        a8 = 8'h55; b8 = 8'h55;
        @(negedge clk);
        check("b2b_done", done8, 1'b1);
        check("b2b_ignored_start", res8, 3'b010);
        a8 = 8'h03; b8 = 8'h02;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_no_gap", busy8, 1'b1);
        lat = 0;
        while (!done8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_lat", lat, 4);
        check("b2b_res", res8, 3'b010);

        @(negedge clk);
        start8 = 1'b1; a8 = 8'h00; b8 = 8'h00;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort8_outs", {busy8, done8, res8}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        check("abort8_no_done", seen, 1'b0);
        check("abort8_res", res8, 3'b000);

        run(1'b1, 16'hFFFF, 16'hFFFE, 1'b1, lat, bcnt);
        check("w16_lat", lat, 4);
        check("w16_res", res16, 3'b010);

        @(negedge clk);
        start16 = 1'b1; a16 = 16'h0000; b16 = 16'h0000; sgn16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort16_outs", {busy16, done16, res16}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done16) seen = 1'b1;
        end
        check("abort16_no_done", seen, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
